// File: rtl/instr_decoder.sv
// Instruction decoder for a 12-bit baseline core: free-running Q1..Q4 phase counter,
// instruction register with pipeline flush, and registered per-phase control strobes.
module instr_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [11:0] instrIn,
   input  logic       aluZero,
   output logic [1:0] qPhase,
   output logic [4:0] fileAddr,
   output logic       Read_En,
   output logic [2:0] writeCommand,
   output logic       wWriteEn,
   output logic [4:0] aluOp,
   output logic       aluSrcLit,
   output logic [8:0] literal,
   output logic [2:0] bitSel,
   output logic       pcEn,
   output logic [1:0] pcCmd,
   output logic       optionWr,
   output logic       trisWr,
   output logic       sleepReq,
   output logic       clrwdtReq
);
   localparam int unsigned IR_W = 12;

   localparam logic [4:0] ALU_PASSW = 5'd0,  ALU_ADD   = 5'd1,  ALU_SUB  = 5'd2,
                          ALU_AND   = 5'd3,  ALU_IOR   = 5'd4,  ALU_XOR  = 5'd5,
                          ALU_COM   = 5'd6,  ALU_INC   = 5'd7,  ALU_DEC  = 5'd8,
                          ALU_PASSF = 5'd9,  ALU_RRF   = 5'd10, ALU_RLF  = 5'd11,
                          ALU_SWAP  = 5'd12, ALU_CLR   = 5'd13, ALU_BCLR = 5'd14,
                          ALU_BSET  = 5'd15, ALU_BTEST = 5'd16, ALU_PASSL = 5'd17;

   localparam logic [2:0] WC_NONE = 3'b000, WC_STATUS = 3'b001,
                          WC_FILE = 3'b010, WC_FILESTAT = 3'b011;

   localparam logic [1:0] PC_INC = 2'b00, PC_GOTO = 2'b01, PC_CALL = 2'b10, PC_RETLW = 2'b11;

   typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} qState_t;

   qState_t         state, stateNext;
   logic [IR_W-1:0] ir, irNext, irLoad;
   logic            flush, flushNext;
   logic            readEnNext, aluSrcLitNext;
   logic [4:0]      aluOpNext;
   logic [2:0]      wcNext;
   logic            wweNext, pcEnNext, optNext, trisNext, sleepNext, wdtNext;
   logic [1:0]      pcCmdNext;

   logic [2:0]      dWc;
   logic [1:0]      dPcCmd;
   logic            dWwe, dOpt, dTris, dSleep, dWdt, dSkip, dBranch;

   // File operand: byte/bit ops, excluding the 0000_000x_xxxx specials
   function automatic logic isFileOp(input logic [6:0] hi);
      return (hi[6:5] == 2'b00 && hi[4:0] != 5'd0) || hi[6:5] == 2'b01;
   endfunction

   function automatic logic isLitOp(input logic [3:0] op);
      return op[3:2] == 2'b11 || op == 4'b1000;
   endfunction

   function automatic logic [4:0] aluOpOf(input logic [5:0] op);
      logic [4:0] r;
      r = ALU_PASSW;
      casez (op)
         6'b000001: r = ALU_CLR;
         6'b000010: r = ALU_SUB;
         6'b000011: r = ALU_DEC;
         6'b000100: r = ALU_IOR;
         6'b000101: r = ALU_AND;
         6'b000110: r = ALU_XOR;
         6'b000111: r = ALU_ADD;
         6'b001000: r = ALU_PASSF;
         6'b001001: r = ALU_COM;
         6'b001010: r = ALU_INC;
         6'b001011: r = ALU_DEC;
         6'b001100: r = ALU_RRF;
         6'b001101: r = ALU_RLF;
         6'b001110: r = ALU_SWAP;
         6'b001111: r = ALU_INC;
         6'b0100??: r = ALU_BCLR;
         6'b0101??: r = ALU_BSET;
         6'b011???: r = ALU_BTEST;
         6'b1000??: r = ALU_PASSL;
         6'b1100??: r = ALU_PASSL;
         6'b1101??: r = ALU_IOR;
         6'b1110??: r = ALU_AND;
         6'b1111??: r = ALU_XOR;
         default:   r = ALU_PASSW;
      endcase
      return r;
   endfunction

   // Q4 actions of the instruction held in IR; skip uses aluZero as it stands at the Q3->Q4 edge
   always_comb begin
      dWc = WC_NONE; dWwe = 1'b0; dPcCmd = PC_INC;
      dOpt = 1'b0; dTris = 1'b0; dSleep = 1'b0; dWdt = 1'b0;
      dSkip = 1'b0; dBranch = 1'b0;
      casez (ir[11:6])
         6'b000000: begin
            if (ir[5]) dWc = WC_FILE;
            else begin
               case (ir[4:0])
                  5'd2:              dOpt   = 1'b1;
                  5'd3:              dSleep = 1'b1;
                  5'd4:              dWdt   = 1'b1;
                  5'd5, 5'd6, 5'd7:  dTris  = 1'b1;
                  default:           dOpt   = 1'b0;
               endcase
            end
         end
         6'b000001: begin
            if (ir[5]) dWc = WC_FILESTAT;
            else begin dWc = WC_STATUS; dWwe = 1'b1; end
         end
         6'b00001?, 6'b0001??, 6'b00100?, 6'b001010, 6'b00110?: begin
            dWc  = ir[5] ? WC_FILESTAT : WC_STATUS;
            dWwe = ~ir[5];
         end
         6'b001011, 6'b001111: begin
            dWc   = ir[5] ? WC_FILE : WC_NONE;
            dWwe  = ~ir[5];
            dSkip = aluZero;
         end
         6'b001110: begin
            dWc  = ir[5] ? WC_FILE : WC_NONE;
            dWwe = ~ir[5];
         end
         6'b010???: dWc = WC_FILE;
         6'b0110??: dSkip = aluZero;
         6'b0111??: dSkip = ~aluZero;
         6'b1000??: begin dWwe = 1'b1; dPcCmd = PC_RETLW; dBranch = 1'b1; end
         6'b1001??: begin dPcCmd = PC_CALL; dBranch = 1'b1; end
         6'b101???: begin dPcCmd = PC_GOTO; dBranch = 1'b1; end
         6'b1100??: dWwe = 1'b1;
         default:   begin dWc = WC_STATUS; dWwe = 1'b1; end
      endcase
   end

   // Phase sequencing and next values of all registered outputs
   always_comb begin
      stateNext     = state;
      irLoad        = flush ? 12'h000 : instrIn;
      irNext        = ir;
      flushNext     = flush;
      readEnNext    = 1'b0;
      aluOpNext     = aluOp;
      aluSrcLitNext = aluSrcLit;
      wcNext        = WC_NONE;
      wweNext       = 1'b0;
      pcEnNext      = 1'b0;
      pcCmdNext     = PC_INC;
      optNext       = 1'b0;
      trisNext      = 1'b0;
      sleepNext     = 1'b0;
      wdtNext       = 1'b0;
      case (state)
         Q1: begin
            stateNext     = Q2;
            irNext        = irLoad;
            flushNext     = 1'b0;
            readEnNext    = isFileOp(irLoad[11:5]);
            aluOpNext     = aluOpOf(irLoad[11:6]);
            aluSrcLitNext = isLitOp(irLoad[11:8]);
         end
         Q2: begin
            stateNext  = Q3;
            readEnNext = isFileOp(ir[11:5]);
         end
         Q3: begin
            stateNext = Q4;
            wcNext    = dWc;
            wweNext   = dWwe;
            pcEnNext  = 1'b1;
            pcCmdNext = dPcCmd;
            optNext   = dOpt;
            trisNext  = dTris;
            sleepNext = dSleep;
            wdtNext   = dWdt;
            flushNext = dSkip | dBranch;
         end
         default: stateNext = Q1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= Q1;
         ir           <= '0;
         flush        <= 1'b0;
         Read_En      <= 1'b0;
         aluOp        <= ALU_PASSW;
         aluSrcLit    <= 1'b0;
         writeCommand <= WC_NONE;
         wWriteEn     <= 1'b0;
         pcEn         <= 1'b0;
         pcCmd        <= PC_INC;
         optionWr     <= 1'b0;
         trisWr       <= 1'b0;
         sleepReq     <= 1'b0;
         clrwdtReq    <= 1'b0;
      end else begin
         state        <= stateNext;
         ir           <= irNext;
         flush        <= flushNext;
         Read_En      <= readEnNext;
         aluOp        <= aluOpNext;
         aluSrcLit    <= aluSrcLitNext;
         writeCommand <= wcNext;
         wWriteEn     <= wweNext;
         pcEn         <= pcEnNext;
         pcCmd        <= pcCmdNext;
         optionWr     <= optNext;
         trisWr       <= trisNext;
         sleepReq     <= sleepNext;
         clrwdtReq    <= wdtNext;
      end
   end

   assign qPhase   = state;
   assign fileAddr = ir[4:0];
   assign literal  = ir[8:0];
   assign bitSel   = ir[7:5];

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: a mnemonic-level reference model queues the expected
// behaviour of each instruction cycle; a monitor checks every phase against the queue head.
module tb_instr_decoder;
   logic       clk, rst, aluZero;
   logic [11:0] instrIn;
   logic [1:0] qPhase, pcCmd;
   logic [4:0] fileAddr, aluOp;
   logic       Read_En, wWriteEn, aluSrcLit, pcEn, optionWr, trisWr, sleepReq, clrwdtReq;
   logic [2:0] writeCommand, bitSel;
   logic [8:0] literal;

   instr_decoder dut (
      .clk(clk), .rst(rst), .instrIn(instrIn), .aluZero(aluZero), .qPhase(qPhase),
      .fileAddr(fileAddr), .Read_En(Read_En), .writeCommand(writeCommand), .wWriteEn(wWriteEn),
      .aluOp(aluOp), .aluSrcLit(aluSrcLit), .literal(literal), .bitSel(bitSel), .pcEn(pcEn),
      .pcCmd(pcCmd), .optionWr(optionWr), .trisWr(trisWr), .sleepReq(sleepReq),
      .clrwdtReq(clrwdtReq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum logic [5:0] {
      M_NOP, M_RSV, M_OPTION, M_SLEEP, M_CLRWDT, M_TRIS, M_MOVWF, M_CLRW, M_CLRF,
      M_SUBWF, M_DECF, M_IORWF, M_ANDWF, M_XORWF, M_ADDWF, M_MOVF, M_COMF, M_INCF,
      M_DECFSZ, M_RRF, M_RLF, M_SWAPF, M_INCFSZ, M_BCF, M_BSF, M_BTFSC, M_BTFSS,
      M_RETLW, M_CALL, M_GOTO, M_MOVLW, M_IORLW, M_ANDLW, M_XORLW
   } mn_t;

   typedef struct packed {
      logic [2:0] wc;
      logic       wwe;
      logic [1:0] pcc;
      logic [4:0] op;
      logic       opv;
      logic       lit;
      logic       rd;
      logic       opt, tris, slp, wdt;
      logic [4:0] fa;
      logic [8:0] lt;
      logic [2:0] bs;
   } exp_t;

   mn_t byteOps [14] = '{M_SUBWF, M_DECF, M_IORWF, M_ANDWF, M_XORWF, M_ADDWF, M_MOVF,
                         M_COMF, M_INCF, M_DECFSZ, M_RRF, M_RLF, M_SWAPF, M_INCFSZ};
   mn_t bitOps  [4]  = '{M_BCF, M_BSF, M_BTFSC, M_BTFSS};
   mn_t litOps  [8]  = '{M_RETLW, M_CALL, M_GOTO, M_GOTO, M_MOVLW, M_IORLW, M_ANDLW, M_XORLW};

   exp_t       sbq [$];
   exp_t       e;
   logic [1:0] tbPhase;
   logic       monActive;
   logic       flushM;
   int         nCompared = 0;
   int         nMismatch = 0;

   always @(posedge clk) begin
      if (rst) tbPhase <= 2'd0;
      else     tbPhase <= tbPhase + 2'd1;
   end

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic mn_t decodeMn(input int w);
      if (w == 0)        return M_NOP;
      if (w == 2)        return M_OPTION;
      if (w == 3)        return M_SLEEP;
      if (w == 4)        return M_CLRWDT;
      if (w >= 5 && w <= 7) return M_TRIS;
      if (w < 32)        return M_RSV;
      if (w < 64)        return M_MOVWF;
      if (w < 96)        return M_CLRW;
      if (w < 128)       return M_CLRF;
      if (w < 1024)      return byteOps[w / 64 - 2];
      if (w < 2048)      return bitOps[w / 256 - 4];
      return litOps[w / 256 - 8];
   endfunction

   // Expected behaviour of one executed instruction word
   function automatic exp_t expOf(input logic [11:0] w, input logic az, output logic taken);
      exp_t x;
      mn_t  m;
      logic d, skip;
      m = decodeMn(int'(w));
      d = w[5];
      x = '0;
      x.fa = w[4:0];
      x.lt = w[8:0];
      x.bs = w[7:5];
      x.rd = (int'(w) >= 32) && (int'(w) < 2048);
      x.opv = 1'b1;
      case (m)
         M_MOVWF:                  x.op = 5'd0;
         M_ADDWF:                  x.op = 5'd1;
         M_SUBWF:                  x.op = 5'd2;
         M_ANDWF, M_ANDLW:         x.op = 5'd3;
         M_IORWF, M_IORLW:         x.op = 5'd4;
         M_XORWF, M_XORLW:         x.op = 5'd5;
         M_COMF:                   x.op = 5'd6;
         M_INCF, M_INCFSZ:         x.op = 5'd7;
         M_DECF, M_DECFSZ:         x.op = 5'd8;
         M_MOVF:                   x.op = 5'd9;
         M_RRF:                    x.op = 5'd10;
         M_RLF:                    x.op = 5'd11;
         M_SWAPF:                  x.op = 5'd12;
         M_CLRW, M_CLRF:           x.op = 5'd13;
         M_BCF:                    x.op = 5'd14;
         M_BSF:                    x.op = 5'd15;
         M_BTFSC, M_BTFSS:         x.op = 5'd16;
         M_MOVLW, M_RETLW:         x.op = 5'd17;
         default:                  x.opv = 1'b0;
      endcase
      if (m inside {M_ADDWF, M_SUBWF, M_ANDWF, M_IORWF, M_XORWF, M_COMF, M_DECF, M_INCF,
                    M_MOVF, M_RRF, M_RLF}) begin
         x.wc = d ? 3'b011 : 3'b001;
         x.wwe = ~d;
      end else if (m inside {M_SWAPF, M_DECFSZ, M_INCFSZ}) begin
         x.wc = d ? 3'b010 : 3'b000;
         x.wwe = ~d;
      end else if (m inside {M_MOVWF, M_BCF, M_BSF}) begin
         x.wc = 3'b010;
      end else if (m == M_CLRF) begin
         x.wc = 3'b011;
      end else if (m inside {M_CLRW, M_IORLW, M_ANDLW, M_XORLW}) begin
         x.wc = 3'b001;
         x.wwe = 1'b1;
      end else if (m inside {M_MOVLW, M_RETLW}) begin
         x.wwe = 1'b1;
      end
      x.lit = m inside {M_MOVLW, M_IORLW, M_ANDLW, M_XORLW, M_RETLW};
      x.pcc = (m == M_GOTO) ? 2'b01 : (m == M_CALL) ? 2'b10 : (m == M_RETLW) ? 2'b11 : 2'b00;
      x.opt  = (m == M_OPTION);
      x.tris = (m == M_TRIS);
      x.slp  = (m == M_SLEEP);
      x.wdt  = (m == M_CLRWDT);
      skip = ((m inside {M_DECFSZ, M_INCFSZ, M_BTFSC}) && az) || (m == M_BTFSS && !az);
      taken = skip || (m inside {M_GOTO, M_CALL, M_RETLW});
      return x;
   endfunction

   task automatic drive(input logic [11:0] w, input logic az);
      logic [11:0] eff;
      logic        taken;
      exp_t        x;
      instrIn = w;
      aluZero = az;
      eff = flushM ? 12'h000 : w;
      x = expOf(eff, az, taken);
      flushM = taken;
      sbq.push_back(x);
   endtask

   task automatic issue(input logic [11:0] w, input logic az);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         if (qPhase == 2'd0) found = 1'b1;
      end
      if (!found) begin
         nCompared++;
         nMismatch++;
         $display("FAIL q1_wait: qPhase=%0d never reached 0 within 8 cycles", qPhase);
      end
      drive(w, az);
      @(posedge clk);
   endtask

   task automatic checkZero(input string name);
      cmp(name, 64'({qPhase, fileAddr, Read_En, writeCommand, wWriteEn, aluOp, aluSrcLit,
                     literal, bitSel, pcEn, optionWr, trisWr, sleepReq, clrwdtReq}), 64'd0);
   endtask

   // Monitor: every phase is checked against the head of the expected queue
   always @(negedge clk) begin
      if (monActive && !rst) begin
         cmp("qPhase", 64'(qPhase), 64'(tbPhase));
         if (tbPhase == 2'd0) begin
            cmp("Read_En_q1", 64'(Read_En), 64'd0);
            cmp("strobes_q1", 64'({writeCommand, wWriteEn, pcEn, optionWr, trisWr, sleepReq,
                                  clrwdtReq}), 64'd0);
         end else if (sbq.size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL scoreboard_empty: no expected entry in phase %0d", tbPhase);
         end else begin
            e = sbq[0];
            cmp("fields", 64'({fileAddr, literal, bitSel}), 64'({e.fa, e.lt, e.bs}));
            if (tbPhase == 2'd3) begin
               cmp("Read_En_q4", 64'(Read_En), 64'd0);
               cmp("strobes_q4",
                   64'({writeCommand, wWriteEn, pcEn, pcCmd, optionWr, trisWr, sleepReq, clrwdtReq}),
                   64'({e.wc, e.wwe, 1'b1, e.pcc, e.opt, e.tris, e.slp, e.wdt}));
               cmp("aluSrcLit", 64'(aluSrcLit), 64'(e.lit));
               if (e.opv) cmp("aluOp", 64'(aluOp), 64'(e.op));
               void'(sbq.pop_front());
            end else begin
               cmp("Read_En", 64'(Read_En), 64'(e.rd));
               cmp("strobes_idle", 64'({writeCommand, wWriteEn, pcEn, optionWr, trisWr, sleepReq,
                                        clrwdtReq}), 64'd0);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [11:0] w;
      bit          drained;
      rst = 1'b1; instrIn = 12'h000; aluZero = 1'b0; monActive = 1'b0; flushM = 1'b0;
      repeat (3) @(posedge clk);
      #1 checkZero("reset_state");

      // First post-reset instruction is sampled at the end of the reset Q1
      @(negedge clk);
      rst = 1'b0;
      drive(12'h1E9, 1'b0);
      monActive = 1'b1;
      @(posedge clk);

      issue(12'h2EA, 1'b1);
      issue(12'hC55, 1'b0);
      issue(12'h766, 1'b0);
      issue(12'hC55, 1'b0);
      issue(12'h766, 1'b1);
      issue(12'hC55, 1'b0);
      issue(12'hB23, 1'b0);
      issue(12'hC55, 1'b0);
      issue(12'h006, 1'b0);
      issue(12'h001, 1'b0);
      issue(12'h003, 1'b0);
      issue(12'h002, 1'b0);
      issue(12'h004, 1'b0);
      issue(12'h007, 1'b0);

      for (int i = 0; i < 300; i++) begin
         w = 12'($urandom_range(0, 4095));
         if (w == 12'h005) w = 12'h006;
         issue(w, 1'($urandom_range(0, 1)));
      end

      // Reset in Q3 of MOVWF aborts it before its Q4 write
      issue(12'h000, 1'b0);
      issue(12'h028, 1'b0);
      for (int i = 0; i < 8 && qPhase != 2'd2; i++) @(negedge clk);
      monActive = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      cmp("midrst_writeCommand", 64'(writeCommand), 64'd0);
      checkZero("midrst_state");
      @(negedge clk);
      rst = 1'b0;
      sbq.delete();
      flushM = 1'b0;
      drive(12'hC55, 1'b0);
      monActive = 1'b1;
      @(posedge clk);
      issue(12'hB23, 1'b0);
      issue(12'h1E9, 1'b0);
      issue(12'h028, 1'b0);

      drained = 1'b0;
      for (int i = 0; i < 16 && !drained; i++) begin
         @(negedge clk);
         if (sbq.size() == 0) drained = 1'b1;
      end
      cmp("scoreboard_drain", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end
endmodule
